// File: rtl/trigger_fill_ctrl.sv
// Trigger-fill sprite sequencer: maps scan position to sprite ROM addresses, absorbs the ROM's
// one-cycle read latency and masks the sprite bottom-up by a per-frame ramped trigger level.
module trigger_fill_ctrl #(
   parameter int unsigned SPR_W      = 584,
   parameter int unsigned SPR_H      = 167,
   parameter int unsigned X0         = 28,
   parameter int unsigned Y0         = 150,
   parameter int unsigned FILL_STEP  = 4,
   parameter logic [11:0] FILL_COLOR = 12'hFFF,
   parameter logic [11:0] DIM_COLOR  = 12'h333
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  hpos,
   input  logic [9:0]  vpos,
   input  logic        frame_start,
   input  logic [7:0]  fill_level,
   output logic [7:0]  rom_row,
   output logic [9:0]  rom_col,
   input  logic [11:0] rom_data,
   output logic        pix_valid,
   output logic [11:0] pix_color,
   output logic [7:0]  disp_level
);

   // Streaming pipeline: no stalls and no handshake, one scan position accepted every cycle.
   logic [7:0]  rom_row_q, rom_row_d;
   logic [9:0]  rom_col_q, rom_col_d;
   logic        win1_q, win1_d, lit1_q, lit1_d;
   logic        win2_q, win2_d, lit2_q, lit2_d;
   logic        pix_valid_q, pix_valid_d;
   logic [11:0] pix_color_q, pix_color_d;
   logic [7:0]  disp_level_q, disp_level_d;
   logic [7:0]  fill_rows_q, fill_rows_d;

   logic [10:0] h_w, v_w, rel_y, lit_thresh;
   logic        in_win;
   logic [7:0]  diff;
   logic [15:0] prod;

   always_comb begin
      h_w        = {1'b0, hpos};
      v_w        = {1'b0, vpos};
      in_win     = (h_w >= 11'(X0)) && (h_w < 11'(X0 + SPR_W)) &&
                   (v_w >= 11'(Y0)) && (v_w < 11'(Y0 + SPR_H));
      rel_y      = v_w - 11'(Y0);
      lit_thresh = 11'(SPR_H) - {3'b000, fill_rows_q};

      rom_row_d  = in_win ? 8'(vpos - 10'(Y0)) : 8'd0;
      rom_col_d  = in_win ? (hpos - 10'(X0)) : 10'd0;
      win1_d     = in_win;
      lit1_d     = in_win && (rel_y >= lit_thresh);

      win2_d     = win1_q;
      lit2_d     = lit1_q;

      pix_valid_d = win2_q && (rom_data != 12'd0);
      if (!pix_valid_d)
         pix_color_d = 12'd0;
      else if (lit2_q)
         pix_color_d = FILL_COLOR;
      else
         pix_color_d = DIM_COLOR;

      // Ramp toward the target by at most FILL_STEP; the min() keeps it inside 0..255.
      disp_level_d = disp_level_q;
      diff         = 8'd0;
      if (frame_start) begin
         if (fill_level > disp_level_q) begin
            diff         = fill_level - disp_level_q;
            disp_level_d = disp_level_q + ((diff > 8'(FILL_STEP)) ? 8'(FILL_STEP) : diff);
         end else if (fill_level < disp_level_q) begin
            diff         = disp_level_q - fill_level;
            disp_level_d = disp_level_q - ((diff > 8'(FILL_STEP)) ? 8'(FILL_STEP) : diff);
         end
      end

      // Ceiling of level*SPR_H/256, so any non-zero level lights at least one row.
      prod        = 16'(disp_level_q) * 16'(SPR_H) + 16'd255;
      fill_rows_d = 8'(prod >> 8);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rom_row_q    <= 8'd0;
         rom_col_q    <= 10'd0;
         win1_q       <= 1'b0;
         lit1_q       <= 1'b0;
         win2_q       <= 1'b0;
         lit2_q       <= 1'b0;
         pix_valid_q  <= 1'b0;
         pix_color_q  <= 12'd0;
         disp_level_q <= 8'd0;
         fill_rows_q  <= 8'd0;
      end else begin
         rom_row_q    <= rom_row_d;
         rom_col_q    <= rom_col_d;
         win1_q       <= win1_d;
         lit1_q       <= lit1_d;
         win2_q       <= win2_d;
         lit2_q       <= lit2_d;
         pix_valid_q  <= pix_valid_d;
         pix_color_q  <= pix_color_d;
         disp_level_q <= disp_level_d;
         fill_rows_q  <= fill_rows_d;
      end
   end

   assign rom_row    = rom_row_q;
   assign rom_col    = rom_col_q;
   assign pix_valid  = pix_valid_q;
   assign pix_color  = pix_color_q;
   assign disp_level = disp_level_q;

endmodule

// File: tb/tb_trigger_fill_ctrl.sv
// Directed bench for trigger_fill_ctrl: addressing, 3-cycle pixel latency, level ramp,
// fill boundary, transparency and mid-line reset.
module tb_trigger_fill_ctrl;

   logic        clk;
   logic        rst_n;
   logic [9:0]  hpos;
   logic [9:0]  vpos;
   logic        frame_start;
   logic [7:0]  fill_level;
   logic [7:0]  rom_row;
   logic [9:0]  rom_col;
   logic [11:0] rom_data;
   logic        pix_valid;
   logic [11:0] pix_color;
   logic [7:0]  disp_level;

   int n_checks = 0;
   int n_errors = 0;

   // Vector table: scan position, ROM word for that position, expected address and pixel.
   logic [9:0]  v_h[$];
   logic [9:0]  v_v[$];
   logic [11:0] v_rom[$];
   logic [7:0]  v_row[$];
   logic [9:0]  v_col[$];
   logic        v_val[$];
   logic [11:0] v_clr[$];

   trigger_fill_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hpos        (hpos),
      .vpos        (vpos),
      .frame_start (frame_start),
      .fill_level  (fill_level),
      .rom_row     (rom_row),
      .rom_col     (rom_col),
      .rom_data    (rom_data),
      .pix_valid   (pix_valid),
      .pix_color   (pix_color),
      .disp_level  (disp_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input logic [9:0] h, input logic [9:0] v, input logic [11:0] rom,
                          input logic [7:0] row, input logic [9:0] col,
                          input logic val, input logic [11:0] clr);
      v_h.push_back(h);
      v_v.push_back(v);
      v_rom.push_back(rom);
      v_row.push_back(row);
      v_col.push_back(col);
      v_val.push_back(val);
      v_clr.push_back(clr);
   endtask

   // Vector k is presented in cycle k; its ROM word is returned in cycle k+2; the pixel
   // is visible after the third edge.
   task automatic run_vecs(input string name);
      int n;
      n = v_h.size();
      for (int i = 0; i < n + 2; i++) begin
         hpos     = (i < n) ? v_h[i] : 10'd0;
         vpos     = (i < n) ? v_v[i] : 10'd0;
         rom_data = (i >= 2) ? v_rom[i-2] : 12'd0;
         step();
         if (i < n) begin
            check($sformatf("%s_row%0d", name, i), 32'(rom_row), 32'(v_row[i]));
            check($sformatf("%s_col%0d", name, i), 32'(rom_col), 32'(v_col[i]));
         end
         if (i >= 2) begin
            check($sformatf("%s_val%0d", name, i-2), 32'(pix_valid), 32'(v_val[i-2]));
            check($sformatf("%s_clr%0d", name, i-2), 32'(pix_color), 32'(v_clr[i-2]));
         end
      end
      rom_data = 12'd0;
      v_h.delete(); v_v.delete(); v_rom.delete(); v_row.delete();
      v_col.delete(); v_val.delete(); v_clr.delete();
   endtask

   task automatic pulse(input logic [7:0] lvl, input int len);
      hpos        = 10'd0;
      vpos        = 10'd0;
      fill_level  = lvl;
      frame_start = 1'b1;
      for (int i = 0; i < len; i++) step();
      frame_start = 1'b0;
   endtask

   initial begin
      int exp_lvl;
      rst_n       = 1'b0;
      hpos        = 10'd100;
      vpos        = 10'd200;
      frame_start = 1'b0;
      fill_level  = 8'd0;
      rom_data    = 12'hFFF;

      // Reset with an in-window scan position
      step();
      step();
      check("rst_row", 32'(rom_row), 32'd0);
      check("rst_col", 32'(rom_col), 32'd0);
      check("rst_val", 32'(pix_valid), 32'd0);
      check("rst_clr", 32'(pix_color), 32'd0);
      check("rst_lvl", 32'(disp_level), 32'd0);
      rst_n = 1'b1;
      step();
      step();

      // Addressing, window edges, transparency at level 0 (all opaque pixels dim)
      add_vec(10'd28,  10'd150, 12'hFFF, 8'd0,   10'd0,   1'b1, 12'h333);
      add_vec(10'd611, 10'd316, 12'hFFF, 8'd166, 10'd583, 1'b1, 12'h333);
      add_vec(10'd27,  10'd150, 12'hFFF, 8'd0,   10'd0,   1'b0, 12'h000);
      add_vec(10'd612, 10'd150, 12'hFFF, 8'd0,   10'd0,   1'b0, 12'h000);
      add_vec(10'd28,  10'd149, 12'hFFF, 8'd0,   10'd0,   1'b0, 12'h000);
      add_vec(10'd28,  10'd317, 12'hFFF, 8'd0,   10'd0,   1'b0, 12'h000);
      add_vec(10'd100, 10'd200, 12'h000, 8'd50,  10'd72,  1'b0, 12'h000);
      add_vec(10'd100, 10'd200, 12'h123, 8'd50,  10'd72,  1'b1, 12'h333);
      run_vecs("addr");

      // Ramp up to 255
      for (int k = 1; k <= 64; k++) begin
         pulse(8'd255, 1);
         exp_lvl = (k < 64) ? 4 * k : 255;
         check($sformatf("ramp_up%0d", k), 32'(disp_level), 32'(exp_lvl));
         step();
      end
      step();

      // Level 255: every opaque pixel lit, including row 0
      add_vec(10'd28,  10'd150, 12'hFFF, 8'd0,   10'd0,   1'b1, 12'hFFF);
      add_vec(10'd611, 10'd316, 12'hFFF, 8'd166, 10'd583, 1'b1, 12'hFFF);
      add_vec(10'd300, 10'd233, 12'h000, 8'd83,  10'd272, 1'b0, 12'h000);
      run_vecs("full");

      // Ramp down to 0
      for (int k = 1; k <= 64; k++) begin
         pulse(8'd0, 1);
         exp_lvl = (k < 64) ? 255 - 4 * k : 0;
         check($sformatf("ramp_dn%0d", k), 32'(disp_level), 32'(exp_lvl));
         step();
      end
      step();
      add_vec(10'd611, 10'd316, 12'hFFF, 8'd166, 10'd583, 1'b1, 12'h333);
      run_vecs("empty");

      // Up to 128, then level changes without a pulse and a held pulse
      for (int k = 1; k <= 32; k++) pulse(8'd128, 1);
      check("lvl128", 32'(disp_level), 32'd128);
      fill_level = 8'd0;
      for (int i = 0; i < 5; i++) step();
      check("no_pulse_hold", 32'(disp_level), 32'd128);
      pulse(8'd0, 2);
      check("held_pulse_dn", 32'(disp_level), 32'd120);
      pulse(8'd128, 2);
      check("held_pulse_up", 32'(disp_level), 32'd128);
      pulse(8'd128, 1);
      check("equal_hold", 32'(disp_level), 32'd128);
      step();
      step();

      // Fill boundary at level 128: 84 rows lit, so rows 83..166 lit and 82 dim
      add_vec(10'd300, 10'd233, 12'hFFF, 8'd83,  10'd272, 1'b1, 12'hFFF);
      add_vec(10'd300, 10'd232, 12'hFFF, 8'd82,  10'd272, 1'b1, 12'h333);
      add_vec(10'd28,  10'd150, 12'hFFF, 8'd0,   10'd0,   1'b1, 12'h333);
      add_vec(10'd611, 10'd316, 12'hFFF, 8'd166, 10'd583, 1'b1, 12'hFFF);
      add_vec(10'd300, 10'd233, 12'h000, 8'd83,  10'd272, 1'b0, 12'h000);
      run_vecs("bound");

      // Mid-line reset during an active sprite row
      vpos     = 10'd300;
      rom_data = 12'hFFF;
      for (int i = 0; i < 4; i++) begin
         hpos = 10'(100 + i);
         step();
      end
      check("pre_rst_val", 32'(pix_valid), 32'd1);
      check("pre_rst_clr", 32'(pix_color), 32'hFFF);
      rst_n = 1'b0;
      hpos  = 10'd104;
      step();
      check("midrst_val", 32'(pix_valid), 32'd0);
      check("midrst_clr", 32'(pix_color), 32'd0);
      check("midrst_lvl", 32'(disp_level), 32'd0);
      check("midrst_row", 32'(rom_row), 32'd0);
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         hpos = 10'(104 + i);
         step();
         check($sformatf("post_rst_val%0d", i), 32'(pix_valid), (i >= 3) ? 32'd1 : 32'd0);
      end
      check("post_rst_clr", 32'(pix_color), 32'h333);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
